chip8_display_scanout: RTL and testbench

//   Reader side of the chip8_top framebuffer: snapshots the flattened 2048-bit display vector on request and

---
 rtl/chip8_display_scanout.sv | 154 +++++++++++++++
 tb/tb_chip8_display_scanout.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/chip8_display_scanout.sv
// chip8_display_scanout
//   Reader side of the chip8 framebuffer. On frame_start_i the flattened display
//   vector is copied into a shadow register, and the copy is streamed row-major
//   as BEAT_W-pixel beats over a valid/ready interface. Because only the shadow
//   is read, the CPU can keep drawing while a frame is in flight without tearing.
// Ports
//   clk_i           system clock, rising edge
//   reset_i         asynchronous active-high reset
//   display_i       framebuffer, pixel (x,y) = display_i[NPIX-1-(y*WIDTH+x)]
//   frame_start_i   one-cycle request to capture and stream a frame
//   out_data_o      beat pixels, MSB = leftmost pixel
//   out_valid_o     beat present
//   out_ready_i     sink accepts beat when valid & ready at a rising edge
//   out_sof_o       first beat of the frame
//   out_eol_o       last beat of a row
//   out_eof_o       last beat of the frame (also carries eol)
//   busy_o          frame in progress
//   frame_count_o   completed frames, wraps
//   req_dropped_o   sticky: a request arrived while busy and was ignored
module chip8_display_scanout #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 32,
  parameter int BEAT_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [WIDTH*HEIGHT-1:0] display_i,
  input  logic                    frame_start_i,
  output logic [BEAT_W-1:0]       out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    out_sof_o,
  output logic                    out_eol_o,
  output logic                    out_eof_o,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        frame_count_o,
  output logic                    req_dropped_o
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int BPR  = WIDTH / BEAT_W;                  // beats per row
  localparam int BW   = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  // Flags of beat (0,0): only degenerate geometries make it an eol/eof beat.
  localparam logic START_EOL = (BPR == 1);
  localparam logic START_EOF = (BPR == 1) && (HEIGHT == 1);

  typedef enum logic {IDLE, STREAM} state_e;

  // Beat k of row y; shifting the row-major vector left puts the wanted
  // pixels at the top so the slice position is constant.
  function automatic logic [BEAT_W-1:0] beat_of(input logic [NPIX-1:0] v,
                                                input int k, input int y);
    logic [NPIX-1:0] sh;
    sh = v << (y * WIDTH + k * BEAT_W);
    return sh[NPIX-1 -: BEAT_W];
  endfunction

  state_e            state_q;
  logic [NPIX-1:0]   shadow_q;
  logic [BW-1:0]     beat_q, beat_d;
  logic [RW-1:0]     row_q, row_d;
  logic [BEAT_W-1:0] data_q, data_d;
  logic              valid_q, sof_q, eol_q, eof_q, busy_q, drop_q;
  logic              eol_d, eof_d;
  logic [CNT_W-1:0]  fcnt_q;
  logic              hs, last_hs, start;

  assign hs      = valid_q & out_ready_i;
  // eof is registered with the beat, so it marks the final beat directly.
  assign last_hs = hs & eof_q;
  // Back-to-back frames: a request on the final handshake restarts at once.
  assign start   = frame_start_i & ((state_q == IDLE) | last_hs);

  // Position and contents of the beat following the one on the bus.
  always_comb begin
    beat_d = beat_q + BW'(1);
    row_d  = row_q;
    if (beat_q == BW'(BPR - 1)) begin
      beat_d = '0;
      row_d  = row_q + RW'(1);
    end
    data_d = beat_of(shadow_q, int'(beat_d), int'(row_d));
    eol_d  = (beat_d == BW'(BPR - 1));
    eof_d  = eol_d & (row_d == RW'(HEIGHT - 1));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      beat_q   <= '0;
      row_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      busy_q   <= 1'b0;
      fcnt_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (last_hs)
        fcnt_q <= fcnt_q + CNT_W'(1);
      if ((state_q == STREAM) && frame_start_i && !last_hs)
        drop_q <= 1'b1;

      if (start) begin
        // First beat comes straight from display_i since the shadow is
        // being written at this same edge.
        state_q  <= STREAM;
        shadow_q <= display_i;
        data_q   <= beat_of(display_i, 0, 0);
        valid_q  <= 1'b1;
        sof_q    <= 1'b1;
        eol_q    <= START_EOL;
        eof_q    <= START_EOF;
        busy_q   <= 1'b1;
        beat_q   <= '0;
        row_q    <= '0;
      end else if (hs) begin
        if (eof_q) begin
          state_q <= IDLE;
          data_q  <= '0;
          valid_q <= 1'b0;
          sof_q   <= 1'b0;
          eol_q   <= 1'b0;
          eof_q   <= 1'b0;
          busy_q  <= 1'b0;
          beat_q  <= '0;
          row_q   <= '0;
        end else begin
          data_q <= data_d;
          sof_q  <= 1'b0;
          eol_q  <= eol_d;
          eof_q  <= eof_d;
          beat_q <= beat_d;
          row_q  <= row_d;
        end
      end
    end
  end

  assign out_data_o    = data_q;
  assign out_valid_o   = valid_q;
  assign out_sof_o     = sof_q;
  assign out_eol_o     = eol_q;
  assign out_eof_o     = eof_q;
  assign busy_o        = busy_q;
  assign frame_count_o = fcnt_q;
  assign req_dropped_o = drop_q;

endmodule

// File: tb/tb_chip8_display_scanout.sv
// Randomized bench for chip8_display_scanout. Expected beats are derived from a
// pixel-level view of the display captured when a frame is requested.
module tb_chip8_display_scanout;
  localparam int W    = 64;
  localparam int H    = 32;
  localparam int BW   = 8;
  localparam int NPIX = W * H;
  localparam int NB   = NPIX / BW;

  logic            clk = 1'b0;
  logic            reset;
  logic [NPIX-1:0] display;
  logic            frame_start, out_ready;
  logic [BW-1:0]   out_data;
  logic            out_valid, out_sof, out_eol, out_eof, busy, req_dropped;
  logic [15:0]     frame_count;

  int errs   = 0;
  int checks = 0;
  logic [12:0] exp_q[$];   // {valid,busy,sof,eol,eof,data}

  chip8_display_scanout dut (
    .clk_i(clk), .reset_i(reset), .display_i(display), .frame_start_i(frame_start),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sof_o(out_sof), .out_eol_o(out_eol), .out_eof_o(out_eof), .busy_o(busy),
    .frame_count_o(frame_count), .req_dropped_o(req_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [12:0] cur();
    return {out_valid, busy, out_sof, out_eol, out_eof, out_data};
  endfunction

  function automatic logic pix(input logic [NPIX-1:0] d, input int x, input int y);
    return d[NPIX-1-(y*W+x)];
  endfunction

  // Reference frame: row-major beats, leftmost pixel in the MSB.
  task automatic build_exp();
    logic [BW-1:0] b;
    logic sof, eol, eof;
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int k = 0; k < W/BW; k++) begin
        for (int i = 0; i < BW; i++) b[BW-1-i] = pix(display, k*BW+i, y);
        sof = (y == 0) && (k == 0);
        eol = (k == W/BW-1);
        eof = eol && (y == H-1);
        exp_q.push_back({1'b1, 1'b1, sof, eol, eof, b});
      end
  endtask

  task automatic rand_disp();
    for (int i = 0; i < NPIX/32; i++) display[i*32 +: 32] = $urandom();
  endtask

  // Called just after a falling edge; request is sampled at the next rise.
  task automatic req();
    frame_start = 1'b1;
    build_exp();
  endtask

  // Drives out_ready at pct% and checks every accepted beat and every stall.
  // mut_at: invert display after that many beats; req_mid: request after that
  // many beats; req_final: request on the final handshake; abort_at: assert
  // reset after that many beats.
  task automatic stream(input int pct, input int mut_at, input int req_mid,
                        input bit req_final, input int abort_at);
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit rdy;
    logic [12:0] prev = '0;
    forever begin
      @(negedge clk);
      frame_start = 1'b0;
      if (cyc == 0) chk("first_beat", {out_valid, out_sof}, 2'b11);
      if (stalled) chk($sformatf("hold%0d", idx), cur(), prev);
      prev = cur();
      cyc++;
      if (cyc > 4000) begin chk("timeout", 0, 1); break; end
      if (idx == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_async", {out_valid, busy}, 0);
        break;
      end
      rdy = ($urandom_range(99) < pct);
      out_ready = rdy;
      stalled = !rdy;
      if (rdy) begin
        chk($sformatf("beat%0d", idx), cur(), exp_q[idx]);
        idx++;
        if (idx == mut_at) display = ~display;
        if (idx == req_mid) frame_start = 1'b1;
        if (idx == NB) begin
          if (req_final) req();
          break;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b1; out_ready = 1'b1;
    rand_disp();
    // Reset held with a request pending.
    repeat (3) @(negedge clk);
    chk("rst_outs", {out_data, out_valid, out_sof, out_eol, out_eof, busy, frame_count, req_dropped}, 0);
    frame_start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", {out_valid, busy}, 0);

    // Corner pixels only, sink always ready.
    display = '0;
    display[NPIX-1] = 1'b1;
    display[0] = 1'b1;
    req(); stream(100, -1, -1, 1'b0, -1);
    @(negedge clk);
    chk("f1_done", {out_valid, busy}, 0);
    chk("f1_count", frame_count, 1);
    chk("f1_nodrop", req_dropped, 0);

    // Same frame under random backpressure.
    req(); stream(50, -1, -1, 1'b0, -1);
    @(negedge clk);
    chk("f2_count", frame_count, 2);

    // Snapshot: all ones captured, display cleared at beat 10.
    display = '1;
    req(); stream(60, 10, -1, 1'b0, -1);
    @(negedge clk);
    chk("f3_count", frame_count, 3);

    // Random images with a random mid-frame overwrite.
    repeat (2) begin
      rand_disp();
      req(); stream(70, $urandom_range(1, 200), -1, 1'b0, -1);
      @(negedge clk);
    end
    chk("f5_count", frame_count, 5);
    chk("f5_nodrop", req_dropped, 0);

    // Dropped request mid-frame, then back-to-back on the final handshake.
    rand_disp();
    req(); stream(80, -1, 100, 1'b1, -1);
    chk("drop_sticky", req_dropped, 1);
    stream(100, -1, -1, 1'b0, -1);
    @(negedge clk);
    chk("b2b_count", frame_count, 7);
    chk("b2b_done", {out_valid, busy}, 0);

    // Reset mid-frame aborts; next request streams from the start.
    rand_disp();
    req(); stream(100, -1, -1, 1'b0, 50);
    chk("abort_state", {frame_count, req_dropped, out_sof, out_eol, out_eof, out_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_idle", {out_valid, busy}, 0);
    rand_disp();
    req(); stream(90, -1, -1, 1'b0, -1);
    @(negedge clk);
    chk("post_abort_count", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
